// File: rtl/counter_port_sched.sv
// Round-robin scheduler sharing one incrementer between counter ports A and B.
// Optional wrap pulses (wrap_a/wrap_b) are enabled by defining COUNTER_SCHED_WRAP_IRQ_EN.
module counter_port_sched #(
  parameter int WIDTH     = 10,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] port_a,
  output logic [WIDTH-1:0] port_b,
  output logic             busy
`ifdef COUNTER_SCHED_WRAP_IRQ_EN
  ,
  output logic             wrap_a,
  output logic             wrap_b
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  logic [1:0]         state_q, state_d;
  logic               last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [WIDTH-1:0]   port_a_q, port_a_d;
  logic [WIDTH-1:0]   port_b_q, port_b_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    burst_d  = burst_q;
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    case (state_q)
      IDLE, GAP: begin
        // On contention the port that was not served last wins.
        if (req_a && (!req_b || last_q == LAST_B)) begin
          state_d = GNT_A;
          last_d  = LAST_A;
          burst_d = '0;
        end else if (req_b) begin
          state_d = GNT_B;
          last_d  = LAST_B;
          burst_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_A: begin
        if (req_a) begin
          port_a_d = port_a_q + WIDTH'(1);
          burst_d  = burst_q + BURST_W'(1);
          if (burst_q == BURST_LAST) state_d = GAP;
        end else begin
          state_d = GAP;
        end
      end
      GNT_B: begin
        if (req_b) begin
          port_b_d = port_b_q + WIDTH'(1);
          burst_d  = burst_q + BURST_W'(1);
          if (burst_q == BURST_LAST) state_d = GAP;
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_a_d = (state_d == GNT_A);
    gnt_b_d = (state_d == GNT_B);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= LAST_B;
      burst_q  <= '0;
      port_a_q <= '0;
      port_b_q <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      port_a_q <= port_a_d;
      port_b_q <= port_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign port_a = port_a_q;
  assign port_b = port_b_q;
  assign busy   = gnt_a_q | gnt_b_q;

`ifdef COUNTER_SCHED_WRAP_IRQ_EN
  logic wrap_a_q, wrap_a_d;
  logic wrap_b_q, wrap_b_d;

  // A pulse marks the edge where the all-ones value rolls over to zero.
  always_comb begin
    wrap_a_d = (state_q == GNT_A) && req_a && (port_a_q == '1);
    wrap_b_d = (state_q == GNT_B) && req_b && (port_b_q == '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_a_q <= 1'b0;
      wrap_b_q <= 1'b0;
    end else begin
      wrap_a_q <= wrap_a_d;
      wrap_b_q <= wrap_b_d;
    end
  end

  assign wrap_a = wrap_a_q;
  assign wrap_b = wrap_b_q;
`endif

endmodule

// File: tb/tb_counter_port_sched.sv
// Directed bench for counter_port_sched: vector table plus multi-cycle sequences.
module tb_counter_port_sched;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_a = 1'b0;
  logic             req_b = 1'b0;
  logic             gnt_a, gnt_b, busy;
  logic [WIDTH-1:0] port_a, port_b;
`ifdef COUNTER_SCHED_WRAP_IRQ_EN
  logic             wrap_a, wrap_b;
`endif

  counter_port_sched dut (
    .clk    (clk),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .port_a (port_a),
    .port_b (port_b),
    .busy   (busy)
`ifdef COUNTER_SCHED_WRAP_IRQ_EN
    ,
    .wrap_a (wrap_a),
    .wrap_b (wrap_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             ra;
    logic             rb;
    logic             ga;
    logic             gb;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    logic exp_a, exp_b;

    vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd2 - 10'd2, 10'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 10'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd2, 10'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd2, 10'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 10'd0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 10'd1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd2, 10'd1};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd2, 10'd1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 10'd1};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 10'd1};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 10'd1};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 10'd2};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 10'd2};
    vt[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 10'd2};
    vt[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 10'd3};
    vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 10'd3};

    // Power-on reset and quiet idle period.
    #1;
    chk("reset_state", {gnt_a, gnt_b, busy, port_a, port_b}, 32'd0);
    #9 reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("idle", {gnt_a, gnt_b, busy, port_a, port_b}, 32'd0);
    end

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req_a = vt[i].ra;
      req_b = vt[i].rb;
      tick();
      chk($sformatf("vec%0d_gnt_a", i), gnt_a, vt[i].ga);
      chk($sformatf("vec%0d_gnt_b", i), gnt_b, vt[i].gb);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].ga | vt[i].gb);
      chk($sformatf("vec%0d_port_a", i), port_a, vt[i].pa);
      chk($sformatf("vec%0d_port_b", i), port_b, vt[i].pb);
    end

    // Single continuous requester: 8 granted cycles, 1 gap.
    do_reset();
    req_a = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      chk("single_gnt_a", gnt_a, (k % 9) != 0);
      chk("single_gnt_b", gnt_b, 1'b0);
    end
    chk("single_port_a", port_a, 32'd24);
    chk("single_port_b", port_b, 32'd0);

    // Both requesting: alternating bursts A, B, A, B.
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      exp_a = ((k % 9) != 0) && ((((k - 1) / 9) % 2) == 0);
      exp_b = ((k % 9) != 0) && ((((k - 1) / 9) % 2) == 1);
      chk("both_gnt_a", gnt_a, exp_a);
      chk("both_gnt_b", gnt_b, exp_b);
      chk("both_overlap", gnt_a & gnt_b, 1'b0);
    end
    chk("both_port_a", port_a, 32'd16);
    chk("both_port_b", port_b, 32'd16);

    // B drops after 3 granted cycles, A takes over after the gap.
    do_reset();
    req_b = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    chk("drop_port_b_mid", port_b, 32'd3);
    req_b = 1'b0;
    req_a = 1'b1;
    tick();
    chk("drop_gap", {gnt_a, gnt_b, busy}, 32'd0);
    chk("drop_port_b", port_b, 32'd3);
    tick();
    chk("drop_gnt_a", gnt_a, 1'b1);
    chk("drop_port_a0", port_a, 32'd0);
    tick();
    chk("drop_port_a1", port_a, 32'd1);
    chk("drop_port_b_hold", port_b, 32'd3);

    // 1024 increments wrap port A back to zero.
    do_reset();
    req_a = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 1152; k++) begin
      tick();
`ifdef COUNTER_SCHED_WRAP_IRQ_EN
      if (wrap_a) pulses++;
      if (k == 1152) chk("wrap_pulse", wrap_a, 1'b1);
`endif
      if (k == 1151) chk("wrap_pre", port_a, 32'd1023);
    end
    chk("wrap_port_a", port_a, 32'd0);
`ifdef COUNTER_SCHED_WRAP_IRQ_EN
    tick();
    if (wrap_a) pulses++;
    chk("wrap_count", pulses, 32'd1);
    chk("wrap_b_quiet", wrap_b, 1'b0);
`endif

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req_a = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    chk("async_pre", port_a, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_clear", {gnt_a, gnt_b, busy, port_a, port_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("async_gnt_a", gnt_a, 1'b1);
    chk("async_port_a0", port_a, 32'd0);
    tick();
    chk("async_port_a1", port_a, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
